// File: rtl/proc_gen2_pkg.sv
// proc_gen2_pkg: shared definitions for the parametrised multicycle processor.
//   - opcode values (compared against the zero-extended opcode field)
//   - timing-state encoding T0..T5
//   - ALU operation select and small decode helpers
package proc_gen2_pkg;

  localparam logic [31:0] OP_MV   = 32'd0;
  localparam logic [31:0] OP_MVI  = 32'd1;
  localparam logic [31:0] OP_ADD  = 32'd2;
  localparam logic [31:0] OP_SUB  = 32'd3;
  localparam logic [31:0] OP_LD   = 32'd4;
  localparam logic [31:0] OP_ST   = 32'd5;
  localparam logic [31:0] OP_MVNZ = 32'd6;
  localparam logic [31:0] OP_AND  = 32'd7;
  localparam logic [31:0] OP_OR   = 32'd8;
  localparam logic [31:0] OP_XOR  = 32'd9;
  localparam logic [31:0] OP_SHR  = 32'd10;
  localparam logic [31:0] OP_SHL  = 32'd11;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_e;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluXor, AluShr, AluShl} alu_op_e;

  function automatic logic is_alu(input logic [31:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL};
  endfunction

  function automatic logic is_shift(input logic [31:0] op);
    return op inside {OP_SHR, OP_SHL};
  endfunction

  // Instructions that run through T5 (6 cycles); everything else finishes at T3.
  function automatic logic is_long(input logic [31:0] op);
    return is_alu(op) || (op inside {OP_MVI, OP_LD, OP_ST});
  endfunction

  function automatic alu_op_e alu_op_of(input logic [31:0] op);
    alu_op_e res;
    res = AluAdd;
    if (op == OP_SUB) res = AluSub;
    if (op == OP_AND) res = AluAnd;
    if (op == OP_OR)  res = AluOr;
    if (op == OP_XOR) res = AluXor;
    if (op == OP_SHR) res = AluShr;
    if (op == OP_SHL) res = AluShl;
    return res;
  endfunction

endpackage

// File: rtl/proc_gen2_alu.sv
// proc_gen2_alu: purely combinational ALU.
//   a_i, b_i  : operands (shifts use a_i only, by one bit, zero fill)
//   op_i      : operation select
//   result_o  : result modulo 2**DATA_W
//   zero_o    : result == 0
module proc_gen2_alu
  import proc_gen2_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      AluShr:  result_o = a_i >> 1;
      AluShl:  result_o = a_i << 1;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/proc_gen2.sv
// proc_gen2: parametrised multicycle processor fetching from a synchronous RAM.
//   Clock : rising-edge clock          Reset : synchronous, active-high
//   Run   : 1 advance, 0 stall         DIN   : RAM read data
//   ADDR  : registered memory address  DOUT  : registered write data
//   W     : write strobe (st, T5)      Done  : last cycle of each instruction
// Register NREGS-1 is the PC.
module proc_gen2
  import proc_gen2_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned IR_W   = OP_W + 2 * REG_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W,
  output logic              Done
);

  localparam int unsigned NREGS = 2 ** REG_W;
  localparam int unsigned PC_IDX = NREGS - 1;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_e            state_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q, g_q, addr_q, dout_q;
  logic [IR_W-1:0]   ir_q;
  logic              z_q;

  logic [31:0]       op;
  logic [REG_W-1:0]  rx, ry;
  logic [DATA_W-1:0] rx_val, ry_val, pc_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  alu_op_e           alu_op;

  always_comb begin
    op     = 32'(ir_q[IR_W-1 -: OP_W]);
    rx     = ir_q[2*REG_W-1 -: REG_W];
    ry     = ir_q[REG_W-1:0];
    rx_val = regs_q[rx];
    ry_val = regs_q[ry];
    pc_val = regs_q[PC_IDX];
    alu_op = alu_op_of(op);
  end

  proc_gen2_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (ry_val),
    .op_i     (alu_op),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Strobes decode the held state, so a stall must mask them to avoid repeats.
  always_comb begin
    Done = Run && ((state_q == T5) || (state_q == T3 && !is_long(op)));
    W    = Run && (state_q == T5) && (op == OP_ST);
  end

  assign ADDR = addr_q;
  assign DOUT = dout_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q     <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else if (Run) begin
      unique case (state_q)
        T0: begin
          addr_q  <= pc_val;
          state_q <= T1;
        end
        T1: begin
          regs_q[PC_IDX] <= pc_val + ONE;
          state_q        <= T2;
        end
        T2: begin
          ir_q    <= DIN[IR_W-1:0];
          state_q <= T3;
        end
        T3: begin
          if (is_long(op)) begin
            if (op == OP_MVI) addr_q <= pc_val;
            if (op == OP_LD || op == OP_ST) addr_q <= ry_val;
            if (is_alu(op)) a_q <= is_shift(op) ? ry_val : rx_val;
            state_q <= T4;
          end else begin
            if (op == OP_MV || (op == OP_MVNZ && !z_q)) regs_q[rx] <= ry_val;
            state_q <= T0;
          end
        end
        T4: begin
          if (op == OP_MVI) regs_q[PC_IDX] <= pc_val + ONE;
          if (op == OP_ST) dout_q <= rx_val;
          if (is_alu(op)) begin
            g_q <= alu_res;
            z_q <= alu_zero;
          end
          state_q <= T5;
        end
        T5: begin
          if (op == OP_MVI || op == OP_LD) regs_q[rx] <= DIN;
          if (is_alu(op)) regs_q[rx] <= g_q;
          state_q <= T0;
        end
        default: state_q <= T0;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_gen2.sv
// Bench for proc_gen2: an instruction-level model executes the same memory image and is
// compared with the processor at every Done; random Run stalls throughout.
module tb_proc_gen2;
  import proc_gen2_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit default instance
  logic        rst, run, w, done;
  logic [15:0] din, addr, dout;
  logic [15:0] ram [65536];

  proc_gen2 #(.DATA_W(16), .REG_W(3), .OP_W(4)) dut (
    .Clock (clk), .Reset (rst), .Run (run), .DIN (din),
    .ADDR (addr), .DOUT (dout), .W (w), .Done (done)
  );

  always @(posedge clk) begin
    if (w) ram[addr] <= dout;
    din <= ram[addr];
  end

  // 8-bit, 4-register instance
  logic       rst8, run8, w8, done8;
  logic [7:0] din8, addr8, dout8;
  logic [7:0] ram8 [256];

  proc_gen2 #(.DATA_W(8), .REG_W(2), .OP_W(4)) dut8 (
    .Clock (clk), .Reset (rst8), .Run (run8), .DIN (din8),
    .ADDR (addr8), .DOUT (dout8), .W (w8), .Done (done8)
  );

  always @(posedge clk) begin
    if (w8) ram8[addr8] <= dout8;
    din8 <= ram8[addr8];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: memory image, registers (7 = PC) and zero flag.
  logic [15:0] mm [65536];
  logic [15:0] mr [8];
  logic        mz;

  task automatic model_exec(output int lat, output bit is_st,
                            output logic [15:0] st_a, output logic [15:0] st_d);
    logic [15:0] inst, res;
    int op, x, y;
    inst  = mm[mr[7]];
    mr[7] = mr[7] + 16'd1;
    op = int'(inst[9:6]);
    x  = int'(inst[5:3]);
    y  = int'(inst[2:0]);
    lat = 4; is_st = 0; st_a = '0; st_d = '0; res = '0;
    case (op)
      0: mr[x] = mr[y];
      1: begin res = mm[mr[7]]; mr[7] = mr[7] + 16'd1; mr[x] = res; lat = 6; end
      2, 3, 7, 8, 9, 10, 11: begin
        case (op)
          2: res = mr[x] + mr[y];
          3: res = mr[x] - mr[y];
          7: res = mr[x] & mr[y];
          8: res = mr[x] | mr[y];
          9: res = mr[x] ^ mr[y];
          10: res = mr[y] / 16'd2;
          default: res = mr[y] * 16'd2;
        endcase
        mz = (res == 16'd0);
        mr[x] = res;
        lat = 6;
      end
      4: begin mr[x] = mm[mr[y]]; lat = 6; end
      5: begin is_st = 1; st_a = mr[y]; st_d = mr[x]; mm[st_a] = st_d; lat = 6; end
      6: if (!mz) mr[x] = mr[y];
      default: ;
    endcase
  endtask

  task automatic wait_done8(input string tag);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1;
    end
    if (!seen) check_eq(tag, done8, 1);
  endtask

  int          lat, cnt, ninstr;
  bit          is_st, pending;
  logic [15:0] st_a, st_d;

  initial begin
    rst = 1; run = 1; rst8 = 1; run8 = 1;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'($urandom);
      mm[i]  = ram[i];
    end
    begin
      logic [15:0] prog [21];
      prog = '{16'h0040, 16'h0005, 16'h0048, 16'h0003, 16'h00C1, 16'h0050, 16'hFFFF,
               16'h0092, 16'h0252, 16'h01BB, 16'h0068, 16'h1000, 16'h0060, 16'h00A5,
               16'h0165, 16'h0070, 16'h0020, 16'h011E, 16'h02DB, 16'h0078, 16'h0040};
      for (int i = 0; i < 21; i++) begin ram[i] = prog[i]; mm[i] = prog[i]; end
    end
    ram[16'h0020] = 16'h1234; mm[16'h0020] = 16'h1234;
    for (int i = 0; i < 256; i++) ram8[i] = 8'h00;
    ram8[0] = 8'h1C; ram8[1] = 8'h10;     // mvi R3(PC),#0x10
    ram8[16] = 8'h10; ram8[17] = 8'hFF;   // mvi R0,#0xFF
    ram8[18] = 8'h20;                     // add R0,R0

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_w_done", {w, done}, 0);
    check_eq("rst_state", 32'(dut.state_q), 32'(T0));
    check_eq("rst_z", dut.z_q, 0);
    for (int i = 0; i < 8; i++) check_eq($sformatf("rst_r%0d", i), dut.regs_q[i], 0);

    // Narrow instance: jump through R3, then an 8-bit wrapping add
    rst8 = 0;
    wait_done8("n8_jump_done");
    @(negedge clk);
    check_eq("n8_pc", dut8.regs_q[3], 8'h10);
    @(negedge clk);
    check_eq("n8_fetch_addr", addr8, 8'h10);
    wait_done8("n8_mvi_done");
    wait_done8("n8_add_done");
    @(negedge clk);
    check_eq("n8_wrap", dut8.regs_q[0], 8'hFE);
    rst8 = 1;

    // Reset asserted at T4 of the first mvi
    rst = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("mid_state_t4", 32'(dut.state_q), 32'(T4));
    check_eq("mid_addr", addr, 16'h0001);
    rst = 1;
    @(negedge clk);
    check_eq("mid_rst_state", 32'(dut.state_q), 32'(T0));
    check_eq("mid_rst_pc", dut.regs_q[7], 0);
    check_eq("mid_rst_addr", addr, 0);
    check_eq("mid_rst_w_done", {w, done}, 0);
    rst = 0;
    @(negedge clk);
    check_eq("refetch_addr", addr, 0);
    @(negedge clk);
    check_eq("refetch_pc", dut.regs_q[7], 16'h0001);
    rst = 1;
    @(negedge clk);
    rst = 0; run = 0;

    // Random-stall run against the model
    for (int i = 0; i < 8; i++) mr[i] = '0;
    mz = 0; cnt = 0; ninstr = 0; pending = 0;
    for (int c = 0; c < 20000 && ninstr < 600; c++) begin
      @(posedge clk);
      #1 run = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (pending) begin
        pending = 0;
        for (int i = 0; i < 8; i++) check_eq($sformatf("r%0d", i), dut.regs_q[i], mr[i]);
        check_eq("z", dut.z_q, mz);
        if (ninstr == 3) check_eq("sub_r0", dut.regs_q[0], 16'h0002);
        if (ninstr == 5) check_eq("add_wrap_r2", dut.regs_q[2], 16'hFFFE);
        if (ninstr == 6) check_eq("xor_z", dut.z_q, 1);
        if (ninstr == 7) check_eq("mvnz_no_jump_pc", dut.regs_q[7], 16'd10);
        if (ninstr == 12) check_eq("ld_r3", dut.regs_q[3], 16'h1234);
        if (ninstr == 13) check_eq("shl_r3", dut.regs_q[3], 16'h2468);
        if (ninstr == 14) check_eq("jump_pc", dut.regs_q[7], 16'h0040);
      end
      if (!run) begin
        check_eq("stall_w_done", {w, done}, 0);
      end else begin
        cnt++;
        if (done) begin
          model_exec(lat, is_st, st_a, st_d);
          check_eq("latency", cnt, lat);
          check_eq("w_at_done", w, is_st);
          if (is_st) begin
            check_eq("st_addr", addr, st_a);
            check_eq("st_dout", dout, st_d);
          end
          if (ninstr == 9) check_eq("st_dir_addr_dout", {addr, dout}, {16'h1000, 16'h00A5});
          cnt = 0;
          pending = 1;
          ninstr++;
        end else if (w) begin
          check_eq("w_stray", w, 0);
        end
      end
    end
    if (ninstr < 600) check_eq("instr_timeout", ninstr, 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
